// File: rtl/crossbar_pkg.sv
// ----------------------------------------------------------------------------
// crossbar_pkg
// Shared types and constants for the crossbar command sequencer.
//   OP_LOAD / OP_SWAP : command opcodes carried in cmd_t.op
//   state_t           : sequencer FSM states
//   DATA_W, NREG      : crossbar data width and register count
//   cmd_t             : packed command {op, sel, data} as stored in the FIFO
// ----------------------------------------------------------------------------
package crossbar_pkg;

   localparam int DATA_W = 8;
   localparam int NREG   = 4;
   localparam int SEL_W  = $clog2(NREG);

   localparam logic OP_LOAD = 1'b0;
   localparam logic OP_SWAP = 1'b1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      SWAP_W    = 2'd2,
      SWAP_WAIT = 2'd3
   } state_t;

   typedef struct packed {
      logic              op;
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] data;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/crossbar_cmd_fifo.sv
// ----------------------------------------------------------------------------
// crossbar_cmd_fifo
// Small synchronous FIFO holding queued crossbar commands.
//   Clock, Reset    : rising-edge clock, asynchronous active-high reset
//   push, push_data : write request and entry (ignored while full)
//   pop             : read request (ignored while empty)
//   head            : entry at the read pointer, valid whenever !empty
//   full, empty     : occupancy flags (count==DEPTH / count==0)
//   count           : current occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module crossbar_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];

   // Storage is not reset: only the pointers and count define validity.
   always_ff @(posedge Clock) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/crossbar_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// crossbar_cmd_sequencer
// Buffers LOAD/SWAP commands and replays them onto the crossbar controls.
//   Clock, Reset               : rising-edge clock, async active-high reset
//   CmdValid/CmdReady          : command handshake (CmdReady = FIFO not full)
//   CmdOp, CmdSel, CmdData     : command opcode, target register, load value
//   Data, Extern, RinExt[1:4]  : crossbar load controls (active in LOAD only)
//   w                          : swap start pulse (SWAP_W only)
//   Busy                       : FSM not idle or commands queued
//   Done                       : last cycle of each command
//   Count                      : FIFO occupancy
// Optional: define CROSSBAR_CMD_SEQUENCER_STATS_EN to add LoadCount and
// SwapCount 16-bit wrapping event counters.
// ----------------------------------------------------------------------------
module crossbar_cmd_sequencer
   import crossbar_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int SWAP_CYCLES = 3
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   CmdValid,
   output logic                   CmdReady,
   input  logic                   CmdOp,
   input  logic [SEL_W-1:0]       CmdSel,
   input  logic [DATA_W-1:0]      CmdData,
   output logic [DATA_W-1:0]      Data,
   output logic                   Extern,
   output logic [1:NREG]          RinExt,
   output logic                   w,
   output logic                   Busy,
   output logic                   Done,
`ifdef CROSSBAR_CMD_SEQUENCER_STATS_EN
   output logic [15:0]            LoadCount,
   output logic [15:0]            SwapCount,
`endif
   output logic [$clog2(DEPTH):0] Count
);

   localparam int CW = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;

   state_t            state_reg;
   logic [SEL_W-1:0]  sel_reg;
   logic [DATA_W-1:0] data_reg;
   logic [CW-1:0]     wait_reg;

   cmd_t              in_cmd;
   cmd_t              head_cmd;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   assign in_cmd   = '{op: CmdOp, sel: CmdSel, data: CmdData};
   assign CmdReady = !fifo_full;
   // The FIFO ignores pop while empty, so idle alone is the pop request.
   assign fifo_pop = (state_reg == IDLE);

   crossbar_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .Clock     (Clock),
      .Reset     (Reset),
      .push      (CmdValid),
      .push_data (in_cmd),
      .pop       (fifo_pop),
      .head      (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (Count)
   );

   // Sequencer FSM. The popped command's load fields are captured at the
   // same edge that leaves IDLE; the opcode only selects the next state.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         data_reg  <= '0;
         wait_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!fifo_empty) begin
                  sel_reg  <= head_cmd.sel;
                  data_reg <= head_cmd.data;
                  state_reg <= (head_cmd.op == OP_SWAP) ? SWAP_W : LOAD;
               end
            end
            LOAD: begin
               state_reg <= IDLE;
            end
            SWAP_W: begin
               state_reg <= SWAP_WAIT;
               wait_reg  <= CW'(SWAP_CYCLES - 1);
            end
            SWAP_WAIT: begin
               if (wait_reg == '0) begin
                  state_reg <= IDLE;
               end else begin
                  wait_reg <= wait_reg - 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registered state, so they never follow the
   // handshake inputs combinationally.
   assign Extern = (state_reg == LOAD);
   assign Data   = (state_reg == LOAD) ? data_reg : '0;
   assign w      = (state_reg == SWAP_W);
   assign Done   = (state_reg == LOAD) ||
                   ((state_reg == SWAP_WAIT) && (wait_reg == '0));
   assign Busy   = (state_reg != IDLE) || !fifo_empty;

   // RinExt[1] is R1 (sel 0) through RinExt[NREG] (sel NREG-1).
   for (genvar gi = 0; gi < NREG; gi++) begin : g_rin
      assign RinExt[gi+1] = (state_reg == LOAD) && (sel_reg == SEL_W'(gi));
   end

`ifdef CROSSBAR_CMD_SEQUENCER_STATS_EN
   logic [15:0] load_cnt_reg;
   logic [15:0] swap_cnt_reg;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         load_cnt_reg <= '0;
         swap_cnt_reg <= '0;
      end else begin
         if (state_reg == LOAD) begin
            load_cnt_reg <= load_cnt_reg + 16'd1;
         end
         if (state_reg == SWAP_W) begin
            swap_cnt_reg <= swap_cnt_reg + 16'd1;
         end
      end
   end

   assign LoadCount = load_cnt_reg;
   assign SwapCount = swap_cnt_reg;
`endif

endmodule

// File: tb/tb_crossbar_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_crossbar_cmd_sequencer
// Directed bench for crossbar_cmd_sequencer (DEPTH=4, SWAP_CYCLES=3).
// A vector table covers single LOAD, back-to-back LOADs and SWAP-then-LOAD;
// hand-written sequences cover FIFO-full back-pressure, reset in mid-swap and,
// when CROSSBAR_CMD_SEQUENCER_STATS_EN is defined, the statistics counters.
// ----------------------------------------------------------------------------
module tb_crossbar_cmd_sequencer;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       CmdValid = 1'b0;
   logic       CmdReady;
   logic       CmdOp = 1'b0;
   logic [1:0] CmdSel = 2'd0;
   logic [7:0] CmdData = 8'd0;
   logic [7:0] Data;
   logic       Extern;
   logic [1:4] RinExt;
   logic       w;
   logic       Busy;
   logic       Done;
   logic [2:0] Count;
`ifdef CROSSBAR_CMD_SEQUENCER_STATS_EN
   logic [15:0] LoadCount;
   logic [15:0] SwapCount;
`endif

   int total_cnt = 0;
   int pass_cnt  = 0;

   always #5 Clock = ~Clock;

   crossbar_cmd_sequencer #(
      .DEPTH       (4),
      .SWAP_CYCLES (3)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .CmdValid (CmdValid),
      .CmdReady (CmdReady),
      .CmdOp    (CmdOp),
      .CmdSel   (CmdSel),
      .CmdData  (CmdData),
      .Data     (Data),
      .Extern   (Extern),
      .RinExt   (RinExt),
      .w        (w),
      .Busy     (Busy),
      .Done     (Done),
`ifdef CROSSBAR_CMD_SEQUENCER_STATS_EN
      .LoadCount(LoadCount),
      .SwapCount(SwapCount),
`endif
      .Count    (Count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, " Data"},     32'(Data),     32'h0);
      chk({tag, " Extern"},   32'(Extern),   32'h0);
      chk({tag, " RinExt"},   32'(RinExt),   32'h0);
      chk({tag, " w"},        32'(w),        32'h0);
      chk({tag, " Done"},     32'(Done),     32'h0);
      chk({tag, " Busy"},     32'(Busy),     32'h0);
      chk({tag, " Count"},    32'(Count),    32'h0);
      chk({tag, " CmdReady"}, 32'(CmdReady), 32'h1);
   endtask

   typedef struct {
      logic       v;
      logic       op;
      logic [1:0] sel;
      logic [7:0] d;
      logic       e_rdy;
      logic [7:0] e_data;
      logic       e_ext;
      logic [3:0] e_rin;
      logic       e_w;
      logic       e_busy;
      logic       e_done;
      logic [2:0] e_cnt;
   } vec_t;

   vec_t vecs [20];

   // Expected order of the six loads in the back-pressure test.
   logic [7:0] bp_data [6];
   logic [1:0] bp_sel  [6];

`ifdef CROSSBAR_CMD_SEQUENCER_STATS_EN
   task automatic push_cmd(input logic op, input logic [1:0] sel, input logic [7:0] d);
      int guard;
      guard = 0;
      CmdValid = 1'b1; CmdOp = op; CmdSel = sel; CmdData = d;
      while (!CmdReady && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) chk("stats push timeout", 32'(guard), 32'd0);
      tick();
      CmdValid = 1'b0;
   endtask
`endif

   initial begin
      // Inputs / expected outputs after the following clock edge.
      //          v  op sel data    rdy data  ext rin      w  busy done cnt
      vecs[0]  = '{1, 0, 2, 8'hA5,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 1};
      vecs[1]  = '{0, 0, 0, 8'h00,  1, 8'hA5, 1, 4'b0010, 0, 1, 1, 0};
      vecs[2]  = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 0, 0, 0};
      vecs[3]  = '{1, 0, 0, 8'h11,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 1};
      vecs[4]  = '{1, 0, 1, 8'h22,  1, 8'h11, 1, 4'b1000, 0, 1, 1, 1};
      vecs[5]  = '{1, 0, 2, 8'h33,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 2};
      vecs[6]  = '{1, 0, 3, 8'h44,  1, 8'h22, 1, 4'b0100, 0, 1, 1, 2};
      vecs[7]  = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 2};
      vecs[8]  = '{0, 0, 0, 8'h00,  1, 8'h33, 1, 4'b0010, 0, 1, 1, 1};
      vecs[9]  = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 1};
      vecs[10] = '{0, 0, 0, 8'h00,  1, 8'h44, 1, 4'b0001, 0, 1, 1, 0};
      vecs[11] = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 0, 0, 0};
      vecs[12] = '{1, 1, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 1};
      vecs[13] = '{1, 0, 1, 8'h5A,  1, 8'h00, 0, 4'b0000, 1, 1, 0, 1};
      vecs[14] = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 1};
      vecs[15] = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 1};
      vecs[16] = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 1, 1, 1};
      vecs[17] = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 1, 0, 1};
      vecs[18] = '{0, 0, 0, 8'h00,  1, 8'h5A, 1, 4'b0100, 0, 1, 1, 0};
      vecs[19] = '{0, 0, 0, 8'h00,  1, 8'h00, 0, 4'b0000, 0, 0, 0, 0};

      for (int k = 0; k < 6; k++) begin
         bp_data[k] = 8'h61 + 8'(k);
         bp_sel[k]  = 2'(k % 4);
      end

      // Reset state.
      tick();
      tick();
      check_idle_outputs("reset");
      Reset = 1'b0;
      tick();

      // Table-driven vectors.
      for (int i = 0; i < 20; i++) begin
         CmdValid = vecs[i].v;
         CmdOp    = vecs[i].op;
         CmdSel   = vecs[i].sel;
         CmdData  = vecs[i].d;
         tick();
         $display("vec %0d: v=%0b op=%0b sel=%0d d=%02h -> ext=%0b rin=%04b data=%02h w=%0b done=%0b busy=%0b cnt=%0d",
                  i, vecs[i].v, vecs[i].op, vecs[i].sel, vecs[i].d,
                  Extern, RinExt, Data, w, Done, Busy, Count);
         chk($sformatf("v%0d CmdReady", i), 32'(CmdReady), 32'(vecs[i].e_rdy));
         chk($sformatf("v%0d Data", i),     32'(Data),     32'(vecs[i].e_data));
         chk($sformatf("v%0d Extern", i),   32'(Extern),   32'(vecs[i].e_ext));
         chk($sformatf("v%0d RinExt", i),   32'(RinExt),   32'(vecs[i].e_rin));
         chk($sformatf("v%0d w", i),        32'(w),        32'(vecs[i].e_w));
         chk($sformatf("v%0d Busy", i),     32'(Busy),     32'(vecs[i].e_busy));
         chk($sformatf("v%0d Done", i),     32'(Done),     32'(vecs[i].e_done));
         chk($sformatf("v%0d Count", i),    32'(Count),    32'(vecs[i].e_cnt));
      end
      CmdValid = 1'b0;

      // Back-pressure: a SWAP then six LOADs with CmdValid held throughout.
      begin
         int         idx;
         int         cyc;
         int         w_seen;
         int         both_seen;
         int         full_seen;
         int         ready_bad;
         logic       accepted;
         logic [7:0] got_data [$];
         logic [3:0] got_rin  [$];
         logic [3:0] exp_rin;

         idx = 0; cyc = 0; w_seen = 0; both_seen = 0; full_seen = 0; ready_bad = 0;
         while ((idx < 7 || Busy) && cyc < 200) begin
            if (idx == 0) begin
               CmdValid = 1'b1; CmdOp = 1'b1; CmdSel = 2'd0; CmdData = 8'h00;
            end else if (idx < 7) begin
               CmdValid = 1'b1; CmdOp = 1'b0;
               CmdSel = bp_sel[idx-1]; CmdData = bp_data[idx-1];
            end else begin
               CmdValid = 1'b0;
            end
            accepted = CmdValid && CmdReady;
            tick();
            cyc++;
            if (accepted) idx++;
            if (Extern) begin
               got_data.push_back(Data);
               got_rin.push_back(RinExt);
            end
            if (w) w_seen++;
            if (w && Extern) both_seen++;
            if (Count == 3'd4) full_seen++;
            if ((Count == 3'd4) == CmdReady) ready_bad++;
         end
         $display("backpressure: cycles=%0d accepted=%0d issued=%0d swaps=%0d full_cycles=%0d",
                  cyc, idx, got_data.size(), w_seen, full_seen);
         chk("bp timeout", 32'(cyc < 200), 32'd1);
         chk("bp issued loads", 32'(got_data.size()), 32'd6);
         chk("bp swap pulses", 32'(w_seen), 32'd1);
         chk("bp w and Extern together", 32'(both_seen), 32'd0);
         chk("bp reached full", 32'(full_seen > 0), 32'd1);
         chk("bp CmdReady vs full", 32'(ready_bad), 32'd0);
         for (int k = 0; k < 6 && k < got_data.size(); k++) begin
            exp_rin = 4'b1000 >> bp_sel[k];
            chk($sformatf("bp order data %0d", k), 32'(got_data[k]), 32'(bp_data[k]));
            chk($sformatf("bp order rin %0d", k),  32'(got_rin[k]),  32'(exp_rin));
         end
      end

      // Reset in the middle of SWAP_WAIT with two LOADs queued.
      begin
         int stale;
         CmdValid = 1'b1; CmdOp = 1'b1; CmdSel = 2'd0; CmdData = 8'h00;
         tick();
         CmdOp = 1'b0; CmdSel = 2'd0; CmdData = 8'h77;
         tick();
         CmdOp = 1'b0; CmdSel = 2'd1; CmdData = 8'h88;
         tick();
         CmdValid = 1'b0;
         tick();
         $display("pre-reset: cnt=%0d busy=%0b w=%0b ext=%0b", Count, Busy, w, Extern);
         chk("midswap Count before reset", 32'(Count), 32'd2);
         chk("midswap Busy before reset", 32'(Busy), 32'd1);
         #2 Reset = 1'b1;
         #1;
         $display("reset asserted mid-swap: cnt=%0d busy=%0b w=%0b ext=%0b", Count, Busy, w, Extern);
         check_idle_outputs("midswap reset");
         tick();
         Reset = 1'b0;
         stale = 0;
         for (int c = 0; c < 12; c++) begin
            tick();
            if (Extern || w || Done) stale++;
         end
         $display("post-reset: stale events=%0d busy=%0b cnt=%0d", stale, Busy, Count);
         chk("midswap stale issue", 32'(stale), 32'd0);
         chk("midswap Busy after release", 32'(Busy), 32'd0);
      end

`ifdef CROSSBAR_CMD_SEQUENCER_STATS_EN
      begin
         int guard;
         Reset = 1'b1;
         tick();
         chk("stats LoadCount in reset", 32'(LoadCount), 32'd0);
         chk("stats SwapCount in reset", 32'(SwapCount), 32'd0);
         Reset = 1'b0;
         push_cmd(1'b0, 2'd0, 8'h01);
         push_cmd(1'b1, 2'd0, 8'h00);
         push_cmd(1'b0, 2'd1, 8'h02);
         push_cmd(1'b0, 2'd2, 8'h03);
         push_cmd(1'b1, 2'd0, 8'h00);
         push_cmd(1'b0, 2'd3, 8'h04);
         push_cmd(1'b0, 2'd0, 8'h05);
         guard = 0;
         while (Busy && guard < 100) begin
            tick();
            guard++;
         end
         $display("stats: LoadCount=%0d SwapCount=%0d", LoadCount, SwapCount);
         chk("stats drain timeout", 32'(guard < 100), 32'd1);
         chk("stats LoadCount", 32'(LoadCount), 32'd5);
         chk("stats SwapCount", 32'(SwapCount), 32'd2);
         Reset = 1'b1;
         #1;
         chk("stats LoadCount after reset", 32'(LoadCount), 32'd0);
         chk("stats SwapCount after reset", 32'(SwapCount), 32'd0);
         tick();
         Reset = 1'b0;
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
